// File: rtl/burst_mem_pkg.sv
// Shared types and constants for the burst memory responder.
package burst_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BEATS         = 4;
  localparam int BEAT_W        = 64;
  localparam int LINE_OFFSET_W = 5;

endpackage

// File: rtl/burst_mem_array.sv
// Single-port word storage: synchronous write, combinational read, no reset.
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BEAT_W-1:0] wdata,
  output logic [BEAT_W-1:0] rdata
);

  logic [BEAT_W-1:0] mem [2**ADDR_W];

  // Commit a word on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/burst_mem_responder.sv
// Line-oriented memory responder: fixed latency, then four 64-bit beats.
//
// state | meaning
// IDLE  | waiting for a read/write request; latches line and direction
// WAIT  | latency countdown (LATENCY-1 cycles)
// BURST | issues beats 0..3; resp/rdata are registered one cycle later
// DONE  | transfer finished; waits for both requests to drop
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int LINE_IDX_W = 8,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [31:0]       pmem_address,
  input  logic [BEAT_W-1:0] pmem_wdata,
  output logic [BEAT_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic              proto_err
);

  localparam int WORD_W = LINE_IDX_W + 2;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t                  state, state_d;
  logic [3:0]              cnt, cnt_d;
  logic [1:0]              beat, beat_d;
  logic [1:0]              resp_beat;
  logic [LINE_IDX_W-1:0]   line_q;
  logic                    is_rd_q;
  logic                    req_any, held, accept, issue, abort, we;
  logic [WORD_W-1:0]       ram_addr;
  logic [BEAT_W-1:0]       ram_q;
  logic                    unused_addr;

  assign unused_addr = ^{pmem_address[31:LINE_IDX_W+LINE_OFFSET_W], pmem_address[LINE_OFFSET_W-1:0]};

  assign req_any = pmem_read | pmem_write;
  // The request that was latched must stay up; when both were high, read wins.
  assign held    = is_rd_q ? pmem_read : pmem_write;
  assign accept  = (state == IDLE) && req_any;
  assign issue   = (state == BURST) && held;
  assign abort   = ((state == WAIT) || (state == BURST)) && !held;

  // Writes land at the edge that ends the resp cycle of their beat.
  assign we       = pmem_resp && !is_rd_q && pmem_write;
  assign ram_addr = we ? {line_q, resp_beat} : {line_q, beat};

  // Next-state, countdown and beat index.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    beat_d  = beat;
    case (state)
      IDLE: begin
        if (req_any) begin
          state_d = (LATENCY == 1) ? BURST : WAIT;
          cnt_d   = CNT_INIT;
          beat_d  = 2'd0;
        end
      end
      WAIT: begin
        if (!held)          state_d = IDLE;
        else if (cnt == 0)  state_d = BURST;
        else                cnt_d   = cnt - 4'd1;
      end
      BURST: begin
        if (!held) begin
          state_d = IDLE;
          beat_d  = 2'd0;
        end else if (beat == 2'd3) begin
          state_d = DONE;
          beat_d  = 2'd0;
        end else begin
          beat_d  = beat + 2'd1;
        end
      end
      DONE: begin
        if (!req_any) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      beat       <= 2'd0;
      resp_beat  <= 2'd0;
      line_q     <= '0;
      is_rd_q    <= 1'b0;
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
      proto_err  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      beat      <= beat_d;
      pmem_resp <= issue;
      if (accept) begin
        line_q  <= pmem_address[LINE_IDX_W+LINE_OFFSET_W-1:LINE_OFFSET_W];
        is_rd_q <= pmem_read;
      end
      if (issue)            resp_beat  <= beat;
      if (issue && is_rd_q) pmem_rdata <= ram_q;
      if ((accept && pmem_read && pmem_write) || abort || (pmem_resp && !held))
        proto_err <= 1'b1;
    end
  end

  burst_mem_array #(.ADDR_W(WORD_W)) u_array (
    .clk   (clk),
    .we    (we),
    .addr  (ram_addr),
    .wdata (pmem_wdata),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_burst_mem_responder.sv
// Bench: two responders (LATENCY 4 and 1) checked against a line/word model.
module tb_burst_mem_responder;
  import burst_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd, wr, resp, perr;
  logic [31:0] addr  [2];
  logic [63:0] wdata [2];
  logic [63:0] rdata [2];

  burst_mem_responder #(.LINE_IDX_W(8), .LATENCY(4)) dut0 (
    .clk(clk), .rst(rst), .pmem_read(rd[0]), .pmem_write(wr[0]),
    .pmem_address(addr[0]), .pmem_wdata(wdata[0]), .pmem_rdata(rdata[0]),
    .pmem_resp(resp[0]), .proto_err(perr[0]));

  burst_mem_responder #(.LINE_IDX_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .pmem_read(rd[1]), .pmem_write(wr[1]),
    .pmem_address(addr[1]), .pmem_wdata(wdata[1]), .pmem_rdata(rdata[1]),
    .pmem_resp(resp[1]), .proto_err(perr[1]));

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int lat_exp [2] = '{4, 1};

  logic [63:0] model [2][1024];
  bit          known [2][1024];
  logic [63:0] wbuf [4];
  logic [63:0] rbuf [4];
  int          n_resp, first_cyc;
  bit          late_resp;

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 5) & 32'hFF);
  endfunction

  function automatic logic [31:0] addr_for(input int line);
    logic [31:0] r;
    r = ($urandom() & 32'hFFFF_E01F) | (32'(line) << 5);
    return r;
  endfunction

  task automatic model_write(input int d, input int line, input int ncommit);
    for (int k = 0; k < ncommit && k < 4; k++) begin
      model[d][line*4+k] = wbuf[k];
      known[d][line*4+k] = 1'b1;
    end
  endtask

  // One initiator transfer. drop_at: drop request once that many beats seen.
  // hold_extra: cycles to keep the request after the final beat.
  // rst_at: assert reset during that beat's resp cycle and return at once.
  task automatic xfer(input int d, input bit r, input bit w, input logic [31:0] a,
                      input int drop_at, input int hold_extra, input int rst_at);
    int  extra = 0;
    int  drop_cyc = -1;
    bit  dropped = 0;
    bit  finished = 0;
    n_resp = 0; first_cyc = -1; late_resp = 0;
    @(negedge clk);
    rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wbuf[0];
    for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
      @(negedge clk);
      if (cyc == 0) addr[d] = $urandom();
      if (!dropped) begin
        wdata[d] = wbuf[n_resp < 4 ? n_resp : 3];
        if (n_resp >= drop_at || (n_resp >= 4 && extra >= hold_extra)) begin
          rd[d] = 1'b0; wr[d] = 1'b0; dropped = 1; drop_cyc = cyc;
        end else if (n_resp >= 4) begin
          extra++;
        end
      end
      if (resp[d]) begin
        if (dropped && cyc > drop_cyc) late_resp = 1;
        if (first_cyc < 0) first_cyc = cyc;
        if (n_resp < 4) rbuf[n_resp] = rdata[d];
        if (rst_at == n_resp) begin
          rst = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0;
          #1;
          return;
        end
        n_resp++;
      end
      if (dropped && cyc >= drop_cyc + 3) finished = 1;
    end
    checks++;
    if (finished) passes++;
    else $display("FAIL xfer_timeout dut%0d: transfer did not complete (beats=%0d), required completion", d, n_resp);
  endtask

  task automatic test_reset;
    rst = 1'b0; rd = '0; wr = '0;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; wdata[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (resp[d] === 1'b0) passes++;
      else $display("FAIL reset_resp dut%0d: got %b want 0", d, resp[d]);
      checks++; if (rdata[d] === 64'd0) passes++;
      else $display("FAIL reset_rdata dut%0d: got %h want 0", d, rdata[d]);
      checks++; if (perr[d] === 1'b0) passes++;
      else $display("FAIL reset_proto_err dut%0d: got %b want 0", d, perr[d]);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_read(input int d);
    wbuf[0] = 64'h1111_1111_1111_1111; wbuf[1] = 64'h2222_2222_2222_2222;
    wbuf[2] = 64'h3333_3333_3333_3333; wbuf[3] = 64'h4444_4444_4444_4444;
    xfer(d, 0, 1, 32'h0000_0040, 99, 0, 99);
    checks++; if (first_cyc == lat_exp[d]) passes++;
    else $display("FAIL wr_latency dut%0d: got %0d want %0d", d, first_cyc, lat_exp[d]);
    checks++; if (n_resp == 4) passes++;
    else $display("FAIL wr_beats dut%0d: got %0d want 4", d, n_resp);
    model_write(d, 2, 4);
    xfer(d, 1, 0, 32'h0000_0040, 99, 0, 99);
    checks++; if (first_cyc == lat_exp[d]) passes++;
    else $display("FAIL rd_latency dut%0d: got %0d want %0d", d, first_cyc, lat_exp[d]);
    checks++; if (n_resp == 4) passes++;
    else $display("FAIL rd_beats dut%0d: got %0d want 4", d, n_resp);
    for (int k = 0; k < 4; k++) begin
      checks++; if (rbuf[k] === model[d][2*4+k]) passes++;
      else $display("FAIL rd_data dut%0d beat%0d: got %h want %h", d, k, rbuf[k], model[d][2*4+k]);
    end
    checks++; if (perr[d] === 1'b0) passes++;
    else $display("FAIL clean_proto_err dut%0d: got %b want 0", d, perr[d]);
  endtask

  task automatic test_held_request;
    xfer(0, 1, 0, 32'h0000_0040, 99, 3, 99);
    checks++; if (n_resp == 4) passes++;
    else $display("FAIL held_no_retrigger: got %0d beats want 4", n_resp);
    xfer(0, 1, 0, 32'h0000_0040, 99, 0, 99);
    checks++; if (n_resp == 4 && rbuf[0] === model[0][8]) passes++;
    else $display("FAIL held_next_request: got %0d beats data %h want 4 beats data %h", n_resp, rbuf[0], model[0][8]);
    checks++; if (perr[0] === 1'b0) passes++;
    else $display("FAIL held_proto_err: got %b want 0", perr[0]);
  endtask

  task automatic test_random;
    for (int i = 0; i < 16; i++) begin
      int d, line;
      bit do_rd;
      d = int'($urandom_range(0, 1));
      line = int'($urandom_range(0, 15));
      do_rd = ($urandom_range(0, 1) == 1);
      for (int k = 0; k < 4; k++) if (!known[d][line*4+k]) do_rd = 0;
      for (int k = 0; k < 4; k++) wbuf[k] = {$urandom(), $urandom()};
      xfer(d, do_rd, !do_rd, addr_for(line), 99, int'($urandom_range(0, 2)), 99);
      checks++; if (first_cyc == lat_exp[d] && n_resp == 4) passes++;
      else $display("FAIL rand_timing dut%0d: first=%0d beats=%0d want first=%0d beats=4", d, first_cyc, n_resp, lat_exp[d]);
      if (do_rd) begin
        for (int k = 0; k < 4; k++) begin
          checks++; if (rbuf[k] === model[d][line*4+k]) passes++;
          else $display("FAIL rand_rd_data dut%0d line%0d beat%0d: got %h want %h", d, line, k, rbuf[k], model[d][line*4+k]);
        end
      end else begin
        model_write(d, line, 4);
      end
    end
  endtask

  task automatic test_both_high;
    for (int k = 0; k < 4; k++) wbuf[k] = {$urandom(), $urandom()};
    xfer(0, 0, 1, 32'h0000_0080, 99, 0, 99);
    model_write(0, 4, 4);
    for (int k = 0; k < 4; k++) wbuf[k] = ~model[0][16+k];
    xfer(0, 1, 1, 32'h0000_0080, 99, 0, 99);
    for (int k = 0; k < 4; k++) begin
      checks++; if (rbuf[k] === model[0][16+k]) passes++;
      else $display("FAIL both_rd_data beat%0d: got %h want %h", k, rbuf[k], model[0][16+k]);
    end
    xfer(0, 1, 0, 32'h0000_0080, 99, 0, 99);
    for (int k = 0; k < 4; k++) begin
      checks++; if (rbuf[k] === model[0][16+k]) passes++;
      else $display("FAIL both_storage beat%0d: got %h want %h", k, rbuf[k], model[0][16+k]);
    end
    checks++; if (perr[0] === 1'b1) passes++;
    else $display("FAIL both_proto_err: got %b want 1", perr[0]);
  endtask

  task automatic test_write_abort;
    for (int k = 0; k < 4; k++) wbuf[k] = {$urandom(), $urandom()};
    xfer(1, 0, 1, addr_for(6), 99, 0, 99);
    model_write(1, 6, 4);
    checks++; if (perr[1] === 1'b0) passes++;
    else $display("FAIL abort_pre_proto_err: got %b want 0", perr[1]);
    for (int k = 0; k < 4; k++) wbuf[k] = {$urandom(), $urandom()};
    xfer(1, 0, 1, addr_for(6), 2, 0, 99);
    model_write(1, 6, 2);
    checks++; if (!late_resp) passes++;
    else $display("FAIL abort_resp_low: got resp after drop want none");
    checks++; if (perr[1] === 1'b1) passes++;
    else $display("FAIL abort_proto_err: got %b want 1", perr[1]);
    xfer(1, 1, 0, addr_for(6), 99, 0, 99);
    for (int k = 0; k < 4; k++) begin
      checks++; if (rbuf[k] === model[1][24+k]) passes++;
      else $display("FAIL abort_storage word%0d: got %h want %h", k, rbuf[k], model[1][24+k]);
    end
  endtask

  task automatic test_reset_mid;
    xfer(0, 1, 0, 32'h0000_0040, 99, 0, 2);
    checks++; if (resp[0] === 1'b0) passes++;
    else $display("FAIL midrst_resp: got %b want 0", resp[0]);
    checks++; if (rdata[0] === 64'd0) passes++;
    else $display("FAIL midrst_rdata: got %h want 0", rdata[0]);
    checks++; if (dut0.state === IDLE) passes++;
    else $display("FAIL midrst_state: got %0d want IDLE", dut0.state);
    checks++; if (perr === 2'b00) passes++;
    else $display("FAIL midrst_proto_err: got %b want 00", perr);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    xfer(0, 1, 0, 32'h0000_2040, 99, 0, 99);
    for (int k = 0; k < 4; k++) begin
      checks++; if (rbuf[k] === model[0][8+k]) passes++;
      else $display("FAIL alias_rd_data beat%0d: got %h want %h", k, rbuf[k], model[0][8+k]);
    end
  endtask

  initial begin
    test_reset();
    test_write_read(0);
    test_write_read(1);
    test_held_request();
    test_random();
    test_both_high();
    test_write_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/burst_mem_responder.md
BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

Interface
REQ-001 SHALL have parameter LINE_IDX_W, default 8, giving the line index width (2^LINE_IDX_W lines of 32 bytes).
REQ-002 SHALL have parameter LATENCY, default 4, giving the number of cycles from request acceptance to the first beat; legal range 1..15.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port pmem_read  input  1  line read request, held by the initiator until the final beat.
REQ-006 SHALL have port pmem_write  input  1  line write request, held by the initiator until the final beat.
REQ-007 SHALL have port pmem_address  input  32  line address; bits [4:0] ignored.
REQ-008 SHALL have port pmem_wdata  input  64  write beat data.
REQ-009 SHALL have port pmem_rdata  output  64  read beat data, registered.
REQ-010 SHALL have port pmem_resp  output  1  beat-valid strobe, high for exactly 4 cycles per transfer.
REQ-011 SHALL have port proto_err  output  1  sticky protocol-violation flag.

Function
REQ-012 SHALL implement the FSM IDLE -> WAIT -> BURST -> DONE -> IDLE.
REQ-013 In IDLE with pmem_read or pmem_write high at rising edge E0, SHALL latch the address line index (pmem_address[LINE_IDX_W+4:5], upper bits ignored so addresses wrap), latch the direction, and enter WAIT.
REQ-014 WAIT SHALL count LATENCY-1 cycles, so that pmem_resp is first high in the cycle after edge E0+LATENCY; with LATENCY=1 it SHALL go directly to BURST.
REQ-015 BURST SHALL assert pmem_resp for 4 consecutive cycles, beats 0..3, word index {line, beat[1:0]}.
REQ-016 For a read, pmem_rdata SHALL hold word {line, k} during beat k's resp cycle.
REQ-017 For a write, the block SHALL store pmem_wdata into word {line, k} at the rising edge ending beat k's resp cycle; the initiator advances wdata after each resp.
REQ-018 After beat 3 the FSM SHALL enter DONE, hold pmem_resp low, and return to IDLE only once pmem_read and pmem_write are both low (no retrigger on a held request).
REQ-019 pmem_address changes after acceptance SHALL be ignored until the next IDLE acceptance.
REQ-020 If read and write are both high at acceptance, the block SHALL service the read, suppress all writes, and set proto_err.
REQ-021 If the latched request drops in WAIT or BURST, the block SHALL abort to IDLE with pmem_resp low next cycle, commit no further writes (beats already written remain), and set proto_err.
REQ-022 proto_err SHALL clear only on reset.
REQ-023 pmem_rdata SHALL keep its last value outside read beats.

Reset
REQ-024 While rst is low, the block SHALL force state=IDLE, beat=0, counter=0, pmem_resp=0, pmem_rdata=0 and proto_err=0, independent of clk.
REQ-025 Storage contents SHALL NOT be reset; they are undefined until written or loaded by the bench.
REQ-026 Reset asserted mid-burst SHALL abort the transfer; beats already written remain in storage.

Structure
REQ-027 Package burst_mem_pkg SHALL hold the FSM state enum, BEATS=4, BEAT_W=64, and LINE_OFFSET_W=5.
REQ-028 Storage SHALL be the sub-module burst_mem_array, a single-port 64-bit synchronous RAM of 2^(LINE_IDX_W+2) words with write enable, no reset.

Verification
REQ-029 Write line 0x0000_0040 with beats 0x11..,0x22..,0x33..,0x44.., then read the same line -> with LATENCY=4, resp is first high 4 cycles after acceptance, resp is high for 4 cycles each time, and the read returns the same four values in order.
REQ-030 Hold pmem_read high for 3 cycles after the final beat -> exactly 4 resp pulses, no second transfer; a new request after the read drops is accepted.
REQ-031 Assert read and write together at 0x80 -> read data returned, storage at 0x80 unchanged, proto_err=1.
REQ-032 Drop pmem_write after beat 1 -> words 0 and 1 updated, words 2 and 3 unchanged, resp low next cycle, proto_err=1.
REQ-033 Pull rst low during beat 2 of a read -> resp=0, rdata=0 and state=IDLE immediately; after release a fresh read at 0x0000_2040 (aliases line 2 with LINE_IDX_W=8) returns line 2's data.
REQ-034 Repeat REQ-029 with LATENCY=1 -> resp is first high in the cycle after the accepting edge.
